accel_job_ctrl: RTL and testbench

ACCEL_JOB_CTRL -- requirements
Module: accel_job_ctrl

---
 rtl/accel_job_ctrl.sv | 159 +++++++++++++++
 tb/tb_accel_job_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_job_ctrl.sv
// Job controller for a streaming accelerator: starts the read/write engines,
// paces words from the read buffer through a fixed-latency kernel, and reports completion.
module accel_job_ctrl #(
  parameter int KERNEL_LATENCY = 3,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [63:0] data_length,
  output logic        rd_sm_run,
  output logic        wr_sm_run,
  input  logic        rd_sm_done,
  input  logic        wr_sm_done,
  input  logic        rbuf_empty,
  output logic        rbuf_rd_enable,
  input  logic        wbuf_full_n,
  output logic        wbuf_wr_enable,
  output logic        idle,
  output logic        done,
  output logic [63:0] words_written,
  output logic        err_run_busy,
  output logic [2:0]  dbg_state
);

  // Handshake: rbuf_rd_enable pops one word in the same cycle it is high;
  // wbuf_wr_enable pushes one kernel result in the same cycle it is high.
  // Engine done inputs may be pulses or levels; they are latched until the job ends.

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                state;
  logic [2:0]                state_nxt;
  logic [63:0]               total_words;
  logic [63:0]               issued;
  logic                      rd_done_seen;
  logic                      wr_done_seen;
  logic [KERNEL_LATENCY-1:0] valid_sr;
  logic                      accept;
  logic                      job_active;

  assign accept     = (state == S_IDLE) && run;
  assign job_active = (state == S_START) || (state == S_RUN) || (state == S_DRAIN);

  assign rbuf_rd_enable = (state == S_RUN) && !rbuf_empty && !wbuf_full_n &&
                          (issued < total_words);
  assign wbuf_wr_enable = valid_sr[KERNEL_LATENCY-1];
  assign rd_sm_run      = (state == S_START);
  assign wr_sm_run      = (state == S_START);
  assign idle           = (state == S_IDLE);
  assign done           = (state == S_DONE);
  assign dbg_state      = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_nxt = (data_length != 64'd0) ? S_START : S_DONE;
        end
      end
      S_START: state_nxt = S_RUN;
      S_RUN: begin
        if (issued >= total_words) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((words_written == total_words) && (valid_sr == '0) &&
            rd_done_seen && wr_done_seen) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_words <= 64'd0;
      issued      <= 64'd0;
    end else if (accept) begin
      total_words <= data_length * 64'(WORDS_PER_LINE);
      issued      <= 64'd0;
    end else if (rbuf_rd_enable) begin
      issued <= issued + 64'd1;
    end
  end

  // words_written holds after the job so the status CSR can still read it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_written <= 64'd0;
    end else if (accept) begin
      words_written <= 64'd0;
    end else if (wbuf_wr_enable) begin
      words_written <= words_written + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_done_seen <= 1'b0;
      wr_done_seen <= 1'b0;
    end else if (accept) begin
      rd_done_seen <= 1'b0;
      wr_done_seen <= 1'b0;
    end else if (job_active) begin
      if (rd_sm_done) rd_done_seen <= 1'b1;
      if (wr_sm_done) wr_done_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_run_busy <= 1'b0;
    end else if (accept) begin
      err_run_busy <= 1'b0;
    end else if (run) begin
      err_run_busy <= 1'b1;
    end
  end

  // The kernel valid pipe shifts unconditionally so results always emerge exactly
  // KERNEL_LATENCY cycles after their pop, regardless of controller state.
  generate
    if (KERNEL_LATENCY == 1) begin : g_sr_one
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_sr <= '0;
        end else begin
          valid_sr <= rbuf_rd_enable;
        end
      end
    end else begin : g_sr_multi
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_sr <= '0;
        end else begin
          valid_sr <= {valid_sr[KERNEL_LATENCY-2:0], rbuf_rd_enable};
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_accel_job_ctrl.sv
// Directed bench for accel_job_ctrl: drivers issue jobs, a negedge monitor
// checks write timing and completion values against queued expectations.
module tb_accel_job_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [63:0] data_length = 64'd0;
  logic        rd_sm_done = 1'b0;
  logic        wr_sm_done = 1'b0;
  logic        rbuf_empty = 1'b0;
  logic        wbuf_full_n = 1'b0;
  logic        rd_sm_run;
  logic        wr_sm_run;
  logic        rbuf_rd_enable;
  logic        wbuf_wr_enable;
  logic        idle;
  logic        done;
  logic [63:0] words_written;
  logic        err_run_busy;
  logic [2:0]  dbg_state;

  accel_job_ctrl #(.KERNEL_LATENCY(LAT), .WORDS_PER_LINE(8)) dut (
    .clk(clk), .rst(rst), .run(run), .data_length(data_length),
    .rd_sm_run(rd_sm_run), .wr_sm_run(wr_sm_run),
    .rd_sm_done(rd_sm_done), .wr_sm_done(wr_sm_done),
    .rbuf_empty(rbuf_empty), .rbuf_rd_enable(rbuf_rd_enable),
    .wbuf_full_n(wbuf_full_n), .wbuf_wr_enable(wbuf_wr_enable),
    .idle(idle), .done(done), .words_written(words_written),
    .err_run_busy(err_run_busy), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [63:0] exp_q[$];
  int          lat_q[$];
  int errors = 0, checks = 0;
  int rd_cnt = 0, wr_cnt = 0, rdrun_cnt = 0, wrrun_cnt = 0, done_cnt = 0;
  int last_rd_cyc = 0, done_cyc = 0, exp_lat = 0;
  logic [63:0] exp_w;

  always @(negedge clk) begin
    if (rbuf_rd_enable) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      lat_q.push_back(cyc + LAT);
    end
    if (wbuf_wr_enable) begin
      wr_cnt++;
      checks++;
      if (lat_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: wbuf_wr_enable at cycle %0d, required none", cyc);
      end else begin
        exp_lat = lat_q.pop_front();
        if (exp_lat != cyc) begin
          errors++;
          $display("FAIL wr_latency: write at cycle %0d, required cycle %0d", cyc, exp_lat);
        end
      end
    end
    if (rst && wbuf_full_n) begin
      checks++;
      if (rbuf_rd_enable) begin
        errors++;
        $display("FAIL stall_rd: rbuf_rd_enable=1 while wbuf_full_n=1 at cycle %0d, required 0", cyc);
      end
    end
    if (rd_sm_run) rdrun_cnt++;
    if (wr_sm_run) wrrun_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done at cycle %0d, required none", cyc);
      end else begin
        exp_w = exp_q.pop_front();
        if (words_written !== exp_w) begin
          errors++;
          $display("FAIL done_words: words_written=%0d, required %0d", words_written, exp_w);
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic int get_cnt(input int which);
    case (which)
      0: return rd_cnt;
      1: return wr_cnt;
      default: return done_cnt;
    endcase
  endfunction

  task automatic wait_cnt(input string name, input int which, input int target, input int budget);
    int n = 0;
    while (get_cnt(which) < target && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (get_cnt(which) < target) begin
      errors++;
      $display("FAIL %s_timeout: count %0d after %0d cycles, required %0d", name, get_cnt(which), budget, target);
    end
  endtask

  int run_cyc = 0;
  task automatic start_job(input logic [63:0] len);
    data_length = len;
    run = 1'b1;
    run_cyc = cyc;
    tick(1);
    run = 1'b0;
  endtask

  task automatic pulse_dones(input logic r, input logic w);
    rd_sm_done = r;
    wr_sm_done = w;
    tick(1);
    rd_sm_done = 1'b0;
    wr_sm_done = 1'b0;
  endtask

  int rd0, wr0, rr0, wr_r0, d0, rdp_cyc;

  task automatic snap();
    rd0 = rd_cnt; wr0 = wr_cnt; rr0 = rdrun_cnt; wr_r0 = wrrun_cnt; d0 = done_cnt;
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_idle", idle, 1);
    chk("rst_rd_en", rbuf_rd_enable, 0);
    chk("rst_wr_en", wbuf_wr_enable, 0);
    chk("rst_sm_run", {rd_sm_run, wr_sm_run}, 0);
    chk("rst_done", done, 0);
    chk("rst_words", words_written, 0);
    chk("rst_err", err_run_busy, 0);
    rst = 1'b1;
    tick(2);

    // one line, dones in DRAIN
    snap();
    exp_q.push_back(64'd8);
    start_job(64'd1);
    wait_cnt("t1_rd", 0, rd0 + 8, 40);
    wait_cnt("t1_wr", 1, wr0 + 8, 40);
    tick(2);
    pulse_dones(1'b1, 1'b1);
    wait_cnt("t1_done", 2, d0 + 1, 20);
    tick(3);
    chk("t1_rd_count", rd_cnt - rd0, 8);
    chk("t1_last_rd_cyc", last_rd_cyc, run_cyc + 9);
    chk("t1_wr_count", wr_cnt - wr0, 8);
    chk("t1_rd_sm_run", rdrun_cnt - rr0, 1);
    chk("t1_wr_sm_run", wrrun_cnt - wr_r0, 1);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_words_hold", words_written, 8);
    chk("t1_idle", idle, 1);

    // zero-length job
    snap();
    exp_q.push_back(64'd0);
    start_job(64'd0);
    wait_cnt("t2_done", 2, d0 + 1, 5);
    tick(2);
    chk("t2_done_cyc", done_cyc, run_cyc + 1);
    chk("t2_rd_sm_run", rdrun_cnt - rr0, 0);
    chk("t2_wr_sm_run", wrrun_cnt - wr_r0, 0);
    chk("t2_rd_count", rd_cnt - rd0, 0);
    chk("t2_words", words_written, 0);

    // two lines with a 10-cycle write-buffer stall
    snap();
    exp_q.push_back(64'd16);
    start_job(64'd2);
    wait_cnt("t3_rd5", 0, rd0 + 5, 40);
    wbuf_full_n = 1'b1;
    tick(10);
    chk("t3_rd_during_stall", rd_cnt - rd0, 5);
    wbuf_full_n = 1'b0;
    wait_cnt("t3_rd", 0, rd0 + 16, 60);
    wait_cnt("t3_wr", 1, wr0 + 16, 60);
    pulse_dones(1'b1, 1'b1);
    wait_cnt("t3_done", 2, d0 + 1, 20);
    tick(2);
    chk("t3_rd_count", rd_cnt - rd0, 16);
    chk("t3_wr_count", wr_cnt - wr0, 16);

    // wr done early, rd done late
    snap();
    exp_q.push_back(64'd8);
    start_job(64'd1);
    wait_cnt("t4_rd3", 0, rd0 + 3, 40);
    pulse_dones(1'b0, 1'b1);
    wait_cnt("t4_wr", 1, wr0 + 8, 40);
    tick(4);
    chk("t4_no_early_done", done_cnt - d0, 0);
    rdp_cyc = cyc;
    pulse_dones(1'b1, 1'b0);
    wait_cnt("t4_done", 2, d0 + 1, 20);
    tick(2);
    chk("t4_done_cyc", done_cyc, rdp_cyc + 2);

    // run while busy
    snap();
    exp_q.push_back(64'd8);
    start_job(64'd1);
    wait_cnt("t5_rd2", 0, rd0 + 2, 40);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    chk("t5_err_set", err_run_busy, 1);
    wait_cnt("t5_wr", 1, wr0 + 8, 40);
    pulse_dones(1'b1, 1'b1);
    wait_cnt("t5_done", 2, d0 + 1, 20);
    tick(2);
    chk("t5_rd_count", rd_cnt - rd0, 8);
    chk("t5_rd_sm_run", rdrun_cnt - rr0, 1);
    chk("t5_err_sticky", err_run_busy, 1);
    exp_q.push_back(64'd0);
    start_job(64'd0);
    chk("t5_err_cleared", err_run_busy, 0);
    tick(3);

    // reset with two valids in flight
    snap();
    start_job(64'd1);
    wait_cnt("t6_rd2", 0, rd0 + 2, 40);
    rst = 1'b0;
    #1;
    lat_q.delete();
    chk("t6_idle", idle, 1);
    chk("t6_rd_en", rbuf_rd_enable, 0);
    chk("t6_wr_en", wbuf_wr_enable, 0);
    chk("t6_state", dbg_state, 0);
    tick(3);
    rst = 1'b1;
    wr0 = wr_cnt;
    tick(10);
    chk("t6_no_writes", wr_cnt - wr0, 0);
    chk("t6_idle_after", idle, 1);
    chk("t6_words", words_written, 0);

    tick(3);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
